// File: rtl/decode_pkg.sv
// Opcode constants, instruction field positions and the destination-write decode shared by decode_stage.
package decode_pkg;
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_STORE  = 4'hE;
  localparam logic [3:0] OP_BRANCH = 4'hF;

  localparam int RD_LSB  = 16;
  localparam int RS1_LSB = 12;
  localparam int RS2_LSB = 8;

  function automatic logic writes_dest(input logic [3:0] op);
    return !(op == OP_NOP || op == OP_STORE || op == OP_BRANCH);
  endfunction
endpackage

// File: rtl/decode_regfile.sv
// REGNUM x WIDTH register file: two combinational read ports, one posedge write port, sync reset to zero.
module decode_regfile #(
  parameter int WIDTH        = 32,
  parameter int REGNUM       = 16,
  parameter int ADDRESSWIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESSWIDTH-1:0] read_address1,
  input  logic [ADDRESSWIDTH-1:0] read_address2,
  output logic [WIDTH-1:0]        read_data1,
  output logic [WIDTH-1:0]        read_data2,
  input  logic                    write_enable,
  input  logic [ADDRESSWIDTH-1:0] write_address,
  input  logic [WIDTH-1:0]        write_data
);
  logic [WIDTH-1:0] regs [REGNUM];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REGNUM; i++) regs[i] <= '0;
    end else if (write_enable) begin
      regs[write_address] <= write_data;
    end
  end

  assign read_data1 = regs[read_address1];
  assign read_data2 = regs[read_address2];
endmodule

// File: rtl/decode_stage.sv
// Decode stage: field split, regfile read, scoreboard stall, ID/EX register (latency 1); inReady drops on
// hazard, flush or a held output. DECODE_BYPASS_EN forwards same-cycle writeback into operands and hazards.
module decode_stage import decode_pkg::*; #(
  parameter int WIDTH            = 32,
  parameter int REGNUM           = 16,
  parameter int ADDRESSWIDTH     = 4,
  parameter int OPCODEWIDTH      = 4,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int IMMWIDTH         = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [INSTRUCTIONWIDTH-1:0] instruction,
  input  logic                        flush,
  input  logic                        writeEnable,
  input  logic [ADDRESSWIDTH-1:0]     writeAddress,
  input  logic [WIDTH-1:0]            dataToSave,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [OPCODEWIDTH-1:0]      opcode,
  output logic [ADDRESSWIDTH-1:0]     regDestinationAddress,
  output logic [ADDRESSWIDTH-1:0]     reg1Address,
  output logic [ADDRESSWIDTH-1:0]     reg2Address,
  output logic [WIDTH-1:0]            reg1Content,
  output logic [WIDTH-1:0]            reg2Content,
  output logic [WIDTH-1:0]            inmediate
);
  logic [OPCODEWIDTH-1:0]  in_op;
  logic [ADDRESSWIDTH-1:0] in_rd, in_rs1, in_rs2;
  logic [WIDTH-1:0]        rf_data1, rf_data2, operand1, operand2;
  logic [REGNUM-1:0]       pend, pend_eff, pend_next;
  logic                    load, hazard, accept, in_writes, out_writes;

  assign in_op      = instruction[INSTRUCTIONWIDTH-1 -: OPCODEWIDTH];
  assign in_rd      = instruction[RD_LSB  +: ADDRESSWIDTH];
  assign in_rs1     = instruction[RS1_LSB +: ADDRESSWIDTH];
  assign in_rs2     = instruction[RS2_LSB +: ADDRESSWIDTH];
  assign in_writes  = writes_dest(4'(in_op));
  assign out_writes = writes_dest(4'(opcode));

  decode_regfile #(
    .WIDTH(WIDTH), .REGNUM(REGNUM), .ADDRESSWIDTH(ADDRESSWIDTH)
  ) regfile (
    .clock(clock),
    .reset(reset),
    .read_address1(in_rs1),
    .read_address2(in_rs2),
    .read_data1(rf_data1),
    .read_data2(rf_data2),
    .write_enable(writeEnable),
    .write_address(writeAddress),
    .write_data(dataToSave)
  );

`ifdef DECODE_BYPASS_EN
  // A register being written back this cycle is already resolved for the reader.
  always_comb begin
    pend_eff = pend;
    if (writeEnable) pend_eff[writeAddress] = 1'b0;
  end
  assign operand1 = (writeEnable && writeAddress == in_rs1) ? dataToSave : rf_data1;
  assign operand2 = (writeEnable && writeAddress == in_rs2) ? dataToSave : rf_data2;
`else
  assign pend_eff = pend;
  assign operand1 = rf_data1;
  assign operand2 = rf_data2;
`endif

  assign load    = !outValid || outReady;
  assign hazard  = pend_eff[in_rs1] || pend_eff[in_rs2] || (in_writes && pend_eff[in_rd]);
  assign inReady = load && !hazard && !flush && !reset;
  assign accept  = inValid && inReady;

  // Set is applied last so an issue wins over a writeback clear of the same register.
  always_comb begin
    pend_next = pend;
    if (writeEnable) pend_next[writeAddress] = 1'b0;
    if (flush && outValid && out_writes) pend_next[regDestinationAddress] = 1'b0;
    if (accept && in_writes) pend_next[in_rd] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) pend <= '0;
    else       pend <= pend_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      outValid              <= 1'b0;
      opcode                <= '0;
      regDestinationAddress <= '0;
      reg1Address           <= '0;
      reg2Address           <= '0;
      reg1Content           <= '0;
      reg2Content           <= '0;
      inmediate             <= '0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (accept) begin
      outValid              <= 1'b1;
      opcode                <= in_op;
      regDestinationAddress <= in_rd;
      reg1Address           <= in_rs1;
      reg2Address           <= in_rs2;
      reg1Content           <= operand1;
      reg2Content           <= operand2;
      inmediate             <= WIDTH'(instruction[IMMWIDTH-1:0]);
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode table, hand-written hazard/hold/flush/reset sequences, random run vs model.
module tb_decode_stage;
  logic        clock, reset, inValid, inReady, flush, writeEnable, outValid, outReady;
  logic [23:0] instruction;
  logic [3:0]  writeAddress, opcode, regDestinationAddress, reg1Address, reg2Address;
  logic [31:0] dataToSave, reg1Content, reg2Content, inmediate;

  typedef struct packed {
    logic        v;
    logic [3:0]  op, rd, rs1, rs2;
    logic [31:0] c1, c2, imm;
  } out_t;

  typedef struct {
    logic [23:0] ins;
    out_t        exp;
  } vec_t;

`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int   total = 0;
  int   bad = 0;
  logic seen_ready;
  out_t dut_o;
  out_t m_out;
  bit          m_pend [16];
  logic [31:0] m_regs [16];
  vec_t tbl [5];

  decode_stage dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .instruction(instruction), .flush(flush), .writeEnable(writeEnable),
    .writeAddress(writeAddress), .dataToSave(dataToSave), .outValid(outValid),
    .outReady(outReady), .opcode(opcode), .regDestinationAddress(regDestinationAddress),
    .reg1Address(reg1Address), .reg2Address(reg2Address), .reg1Content(reg1Content),
    .reg2Content(reg2Content), .inmediate(inmediate)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign dut_o = {outValid, opcode, regDestinationAddress, reg1Address, reg2Address,
                  reg1Content, reg2Content, inmediate};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit tb_wd(input logic [3:0] op);
    return !(op == 4'h0 || op == 4'hE || op == 4'hF);
  endfunction

  // A register is resolved if it has no outstanding writer, or (with forwarding) is written back right now.
  function automatic bit busy(input logic [3:0] a);
    return m_pend[a] && !(BYP && writeEnable && writeAddress == a);
  endfunction

  function automatic logic [31:0] read_op(input logic [3:0] a);
    return (BYP && writeEnable && writeAddress == a) ? dataToSave : m_regs[a];
  endfunction

  task automatic step();
    logic [3:0] op, rd, rs1, rs2;
    logic       exp_ready, acc;
    #1;
    op  = instruction[23:20];
    rd  = instruction[19:16];
    rs1 = instruction[15:12];
    rs2 = instruction[11:8];
    exp_ready = !reset && !flush && (!m_out.v || outReady) && !busy(rs1) && !busy(rs2)
                && !(tb_wd(op) && busy(rd));
    acc = inValid && exp_ready;
    seen_ready = inReady;
    chk("in_ready", inReady, exp_ready);
    if (reset) begin
      m_out = '0;
      for (int i = 0; i < 16; i++) begin
        m_pend[i] = 1'b0;
        m_regs[i] = '0;
      end
    end else begin
      if (writeEnable) m_pend[writeAddress] = 1'b0;
      if (flush && m_out.v && tb_wd(m_out.op)) m_pend[m_out.rd] = 1'b0;
      if (acc && tb_wd(op)) m_pend[rd] = 1'b1;
      if (flush) m_out.v = 1'b0;
      else if (acc) m_out = {1'b1, op, rd, rs1, rs2, read_op(rs1), read_op(rs2), 16'h0, instruction[15:0]};
      else if (outReady) m_out.v = 1'b0;
      if (writeEnable) m_regs[writeAddress] = dataToSave;
    end
    @(posedge clock);
    #1;
    chk("id_ex_model", dut_o, m_out);
  endtask

  task automatic drv(input logic v, input logic [23:0] ins, input logic rdy, input logic fl,
                     input logic we, input logic [3:0] wa, input logic [31:0] wd, input logic rst);
    inValid = v; instruction = ins; outReady = rdy; flush = fl;
    writeEnable = we; writeAddress = wa; dataToSave = wd; reset = rst;
    step();
  endtask

  task automatic do_reset();
    drv(1'b0, 24'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
  endtask

  initial begin
    tbl[0] = '{24'h312345, {1'b1, 4'h3, 4'h1, 4'h2, 4'h3, 32'h0, 32'h0, 32'h0000_2345}};
    tbl[1] = '{24'hE4A5FF, {1'b1, 4'hE, 4'h4, 4'hA, 4'h5, 32'h0, 32'h0, 32'h0000_A5FF}};
    tbl[2] = '{24'h0FFFFF, {1'b1, 4'h0, 4'hF, 4'hF, 4'hF, 32'h0, 32'h0, 32'h0000_FFFF}};
    tbl[3] = '{24'hF00001, {1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0000_0001}};
    tbl[4] = '{24'h7C3B80, {1'b1, 4'h7, 4'hC, 4'h3, 4'hB, 32'h0, 32'h0, 32'h0000_3B80}};

    m_out = '0;
    for (int i = 0; i < 16; i++) begin
      m_pend[i] = 1'b0;
      m_regs[i] = '0;
    end
    inValid = 0; instruction = 0; outReady = 1; flush = 0;
    writeEnable = 0; writeAddress = 0; dataToSave = 0; reset = 1;
    do_reset();
    do_reset();
    chk("reset_state", dut_o, 113'h0);

    // Field decode table, each from a clean reset.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      drv(1'b1, tbl[i].ins, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      chk("decode_table", dut_o, tbl[i].exp);
    end

    // Writeback then read.
    do_reset();
    drv(1'b0, 24'h0, 1'b1, 1'b0, 1'b1, 4'h2, 32'hDEADBEEF, 1'b0);
    drv(1'b1, 24'h102000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("wb_read_rs1", reg1Content, 32'hDEADBEEF);

    // RAW stall released by writeback.
    do_reset();
    drv(1'b1, 24'h150000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    drv(1'b1, 24'h205100, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("raw_stall_1", seen_ready, 1'b0);
    drv(1'b1, 24'h205100, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("raw_stall_2", seen_ready, 1'b0);
    drv(1'b1, 24'h205100, 1'b1, 1'b0, 1'b1, 4'h5, 32'hCAFE0005, 1'b0);
`ifdef DECODE_BYPASS_EN
    chk("raw_wb_cycle_ready", seen_ready, 1'b1);
`else
    chk("raw_wb_cycle_ready", seen_ready, 1'b0);
    drv(1'b1, 24'h205100, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("raw_after_wb_ready", seen_ready, 1'b1);
`endif
    chk("raw_operand", {outValid, opcode, reg1Content}, {1'b1, 4'h2, 32'hCAFE0005});

    // Hold under backpressure.
    do_reset();
    drv(1'b1, 24'h312345, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 24'h4A0000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      chk("hold_not_ready", seen_ready, 1'b0);
      chk("hold_stable", dut_o, tbl[0].exp);
    end
    drv(1'b1, 24'h4A0000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("hold_release", {seen_ready, outValid, opcode, regDestinationAddress}, {1'b1, 1'b1, 4'h4, 4'hA});

    // Flush of a valid writing entry frees its destination.
    do_reset();
    drv(1'b1, 24'h170000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    drv(1'b1, 24'h307000, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("flush_refuse", {seen_ready, outValid}, 2'b00);
    drv(1'b1, 24'h307000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("flush_no_stall", {seen_ready, outValid, reg1Address}, {1'b1, 1'b1, 4'h7});

    // Store does not reserve; reset clears a stall.
    do_reset();
    drv(1'b1, 24'hE40000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    drv(1'b1, 24'h3B4000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("store_no_pend", seen_ready, 1'b1);
    drv(1'b1, 24'h190000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    drv(1'b1, 24'h209000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("pre_reset_stall", seen_ready, 1'b0);
    drv(1'b1, 24'h209000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
    chk("reset_mid_stall", outValid, 1'b0);
    drv(1'b1, 24'h209000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("post_reset_issue", seen_ready, 1'b1);

    // Random traffic; register fields limited to r0..r7 to provoke hazards.
    for (int i = 0; i < 800; i++) begin
      drv($urandom_range(0, 3) != 0,
          {4'($urandom), 1'b0, 3'($urandom), 1'b0, 3'($urandom), 1'b0, 3'($urandom), 8'($urandom)},
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 2) == 0,
          {1'b0, 3'($urandom)},
          $urandom,
          $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
